infix_to_postfix: RTL
=====================

Name: infix_to_postfix

Overview:
- Consumes the token stream written by the ASCII preprocessing stage and converts it to postfix (RPN) order using an internal operator stack (shunting-yard).
- Feeds the downstream postfix evaluator.
- Reads the infix token RAM through a read pointer and writes the postfix token RAM through a write pointer.
- Token encoding:
  - 0x8001 = end
  - 0x8002 = *
  - 0x8003 = /
  - 0x7FFF = +
  - 0x7FFE = -
  - 0x7FFC = (
  - 0x7FFD = )
  - Any other value is a signed 16-bit operand. These seven codes are reserved and are never operands.

Parameters:
- STACK_DEPTH, 16, operator stack entries (power of 2).
- PTR_W, 8, width of the read and write pointers.

Ports:
- Sysclk  in  1  system clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- En  in  1  run enable. While low, the block holds the reset state (synchronous clear). On the rising level it starts conversion at address 0.
- Instr  in  16  token read from the infix RAM. Valid one cycle after R_Pointer changes (synchronous RAM).
- R_Pointer  out  PTR_W  infix RAM read address.
- W_Pointer  out  PTR_W  postfix RAM write address.
- Outstr  out  16  postfix token to write.
- Wr_En  out  1  write strobe for Outstr at W_Pointer; one-cycle pulse.
- Finish  out  1  conversion complete; held until En goes low.
- Error  out  1  malformed input; held until En goes low.

Behaviour:
- Reset (Rst_n=0 asynchronously, or En=0 synchronously):
  - R_Pointer=0, W_Pointer=0, Outstr=0, Wr_En=0, Finish=0, Error=0.
  - Stack pointer = 0 (empty); state = FETCH_WAIT.
  - Deasserting reset mid-conversion discards all progress.
- Precedence: * and / = 2; + and - = 1; ( = 0 (never popped by an operator). All operators are left-associative.
- States:
  - FETCH_WAIT: one cycle for Instr to become valid -> DECODE.
  - DECODE: classify Instr.
    - Operand: Outstr=Instr, Wr_En=1; next cycle W_Pointer+1 and R_Pointer+1 -> FETCH_WAIT.
    - Operator: if the stack is non-empty and prec(top) >= prec(incoming) -> POP_OP. Otherwise -> PUSH.
    - ( -> PUSH.
    - ) -> PAREN.
    - end -> FLUSH.
  - POP_OP: Outstr=top, Wr_En=1, pop; next cycle W_Pointer+1 -> DECODE, re-evaluating the same Instr. One popped operator per 2 cycles.
  - PUSH: push Instr; R_Pointer+1 -> FETCH_WAIT. Pushing when the stack holds STACK_DEPTH entries -> ERR.
  - PAREN:
    - Top is an operator: write it and pop, as in POP_OP, then stay in PAREN.
    - Top is (: pop without writing; R_Pointer+1 -> FETCH_WAIT.
    - Stack empty: -> ERR.
  - FLUSH:
    - Stack non-empty: write the top; if the top is (, go to ERR instead. Pop, W_Pointer+1, repeat.
    - Stack empty: Outstr=0x8001, Wr_En=1 -> DONE.
  - DONE: W_Pointer+1 (final W_Pointer = number of postfix tokens incl. end), Finish=1; hold.
  - ERR: Error=1, Finish=1, Wr_En=0; hold.
- R_Pointer reaching 2^PTR_W-1 without an end token -> ERR (no wrap-around).
- Wr_En is never high in two consecutive cycles. W_Pointer is stable in every cycle where Wr_En=1.
- Unary minus is resolved upstream (negative operands), so this block treats - only as binary.
- No operand/operator alternation check; structural errors are detected only by the rules above.

Test Plan:
- Infix RAM [0x0003,0x7FFF,0x0004,0x8002,0x0002,0x8001] -> postfix [0x0003,0x0004,0x0002,0x8002,0x7FFF,0x8001]; final W_Pointer=6, Finish=1, Error=0.
- [0x7FFC,0x0001,0x7FFF,0x0002,0x7FFD,0x8002,0x0003,0x8001] -> [0x0001,0x0002,0x7FFF,0x0003,0x8002,0x8001]; W_Pointer=6.
- Left associativity: [0x0008,0x7FFE,0x0003,0x7FFE,0x0002,0x8001] -> [0x0008,0x0003,0x7FFE,0x0002,0x7FFE,0x8001]. Operand 0xFFFB (-5) alone -> [0xFFFB,0x8001].
- Errors:
  - [0x0001,0x7FFD,0x8001] (unmatched ')') -> Error=1, Finish=1, no further Wr_En.
  - [0x7FFC,0x0001,0x8001] (unclosed '(') -> Error=1.
  - 17 consecutive 0x7FFC with STACK_DEPTH=16 -> Error=1.
- Drop Rst_n for 1 cycle in the middle of the first test -> all outputs 0 immediately. After release with En=1, the conversion reruns from address 0 with identical output.
- Release En while Finish=1 -> Finish/Error clear next edge, pointers return to 0; re-raise En -> the same result is reproduced.

Source files
------------

// File: rtl/infix_to_postfix.sv
// infix_to_postfix: shunting-yard converter from the infix token RAM to the postfix token RAM.
// Rev 1.0 - initial release.
`default_nettype none

module infix_to_postfix #(
    parameter int STACK_DEPTH = 16,
    parameter int PTR_W       = 8
) (
    input  logic             Sysclk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [15:0]      Instr,
    output logic [PTR_W-1:0] R_Pointer,
    output logic [PTR_W-1:0] W_Pointer,
    output logic [15:0]      Outstr,
    output logic             Wr_En,
    output logic             Finish,
    output logic             Error
);
    localparam int               SP_W    = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] R_MAX   = '1;
    localparam logic [15:0] TOK_END = 16'h8001, TOK_MUL = 16'h8002, TOK_DIV = 16'h8003;
    localparam logic [15:0] TOK_ADD = 16'h7FFF, TOK_SUB = 16'h7FFE;
    localparam logic [15:0] TOK_LP  = 16'h7FFC, TOK_RP  = 16'h7FFD;

    typedef enum logic [2:0] {
        FETCH_WAIT = 3'd0,
        DECODE     = 3'd1,
        POP_OP     = 3'd2,
        PUSH       = 3'd3,
        PAREN      = 3'd4,
        FLUSH      = 3'd5,
        DONE       = 3'd6,
        ERR        = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [15:0]       stack_q [STACK_DEPTH];
    logic              push_en;
    logic [SP_W-2:0]   top_idx;
    logic [15:0]       top;
    logic              empty, full;

    function automatic logic [1:0] prec(input logic [15:0] t);
        if (t == TOK_MUL || t == TOK_DIV)      return 2'd2;
        else if (t == TOK_ADD || t == TOK_SUB) return 2'd1;
        else                                   return 2'd0;
    endfunction

    assign top_idx = sp_q[SP_W-2:0] - 1'b1;
    assign top     = stack_q[top_idx];
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_FULL);

    // Every write state returns through DECODE (or FETCH_WAIT), so Wr_En never
    // asserts in back-to-back cycles; Instr stays valid because R_Pointer holds.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        sp_d    = sp_q;
        push_en = 1'b0;
        Outstr  = 16'h0000;
        Wr_En   = 1'b0;
        Finish  = 1'b0;
        Error   = 1'b0;
        case (state_q)
            FETCH_WAIT: state_d = DECODE;
            DECODE: begin
                if (rptr_q == R_MAX && Instr != TOK_END) begin
                    state_d = ERR;
                end else if (Instr == TOK_END) begin
                    state_d = FLUSH;
                end else if (Instr == TOK_LP) begin
                    state_d = PUSH;
                end else if (Instr == TOK_RP) begin
                    state_d = PAREN;
                end else if (prec(Instr) != 2'd0) begin
                    if (!empty && prec(top) >= prec(Instr)) state_d = POP_OP;
                    else                                     state_d = PUSH;
                end else begin
                    Outstr  = Instr;
                    Wr_En   = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    rptr_d  = rptr_q + 1'b1;
                    state_d = FETCH_WAIT;
                end
            end
            POP_OP: begin
                Outstr  = top;
                Wr_En   = 1'b1;
                sp_d    = sp_q - 1'b1;
                wptr_d  = wptr_q + 1'b1;
                state_d = DECODE;
            end
            PUSH: begin
                if (full) begin
                    state_d = ERR;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + 1'b1;
                    rptr_d  = rptr_q + 1'b1;
                    state_d = FETCH_WAIT;
                end
            end
            PAREN: begin
                if (empty) begin
                    state_d = ERR;
                end else if (top == TOK_LP) begin
                    sp_d    = sp_q - 1'b1;
                    rptr_d  = rptr_q + 1'b1;
                    state_d = FETCH_WAIT;
                end else begin
                    Outstr  = top;
                    Wr_En   = 1'b1;
                    sp_d    = sp_q - 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    state_d = DECODE;
                end
            end
            FLUSH: begin
                if (empty) begin
                    Outstr  = TOK_END;
                    Wr_En   = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    state_d = DONE;
                end else if (top == TOK_LP) begin
                    state_d = ERR;
                end else begin
                    Outstr  = top;
                    Wr_En   = 1'b1;
                    sp_d    = sp_q - 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    state_d = DECODE;
                end
            end
            DONE: Finish = 1'b1;
            ERR: begin
                Finish = 1'b1;
                Error  = 1'b1;
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge Sysclk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= FETCH_WAIT;
            rptr_q  <= '0;
            wptr_q  <= '0;
            sp_q    <= '0;
        end else if (!En) begin
            state_q <= FETCH_WAIT;
            rptr_q  <= '0;
            wptr_q  <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            sp_q    <= sp_d;
        end
    end

    // Stack contents need no reset: only entries below the stack pointer are read.
    always_ff @(posedge Sysclk) begin
        if (push_en && En) stack_q[sp_q[SP_W-2:0]] <= Instr;
    end

    assign R_Pointer = rptr_q;
    assign W_Pointer = wptr_q;

endmodule

`default_nettype wire
